// File: rtl/fifo_sync_param_if.sv
// Handshake bundle for fifo_sync_param.
//   master : producer/consumer side (drives in_valid, in_data, out_ready)
//   slave  : FIFO side (drives in_ready, out_valid, out_data)
// Ports carried:
//   in_valid, in_data[DATA_W], in_ready    write handshake
//   out_valid, out_data[DATA_W], out_ready read handshake (FWFT)
interface fifo_sync_param_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with first-word-fall-through read.
// Buffers words between the host/stimulus side and the AES core.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of contents, count and pointers
//   err_clr      clears overflow; reloads hwm with the next occupancy
//   bus          valid/ready handshakes (slave modport of fifo_sync_param_if)
//   count        occupancy 0..DEPTH
//   almost_full  count >= AFULL_TH
//   almost_empty count <= AEMPTY_TH
//   overflow     sticky: write attempted while full
//   hwm          highest occupancy since reset/err_clr
module fifo_sync_param #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_TH  = DEPTH - 4,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   err_clr,
    fifo_sync_param_if.slave       bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] hwm
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] AFULL_LVL  = CW'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_LVL = CW'(AEMPTY_TH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 2");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("fifo_sync_param: DATA_W must be >= 1");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH > DEPTH - 1) begin : g_bad_th
        $error("fifo_sync_param: threshold out of range");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic [AW:0] hwm_q, hwm_d;
    logic        overflow_q, overflow_d;

    logic full, empty, push, pop, ovf_set;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign push    = bus.in_valid && !full && !flush;
    assign pop     = !empty && bus.out_ready && !flush;
    assign ovf_set = bus.in_valid && full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // A new overflow event beats a simultaneous err_clr.
    assign overflow_d = ovf_set || (overflow_q && !err_clr);

    // err_clr restarts tracking from the current level rather than zero.
    always_comb begin
        hwm_d = hwm_q;
        if (err_clr || (count_d > hwm_q)) hwm_d = count_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hwm_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hwm_q      <= hwm_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= bus.in_data;
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    assign count        = count_q;
    assign almost_full  = (count_q >= AFULL_LVL);
    assign almost_empty = (count_q <= AEMPTY_LVL);
    assign overflow     = overflow_q;
    assign hwm          = hwm_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (DATA_W=32, DEPTH=16, AFULL_TH=12, AEMPTY_TH=2).
// A queue holds the words the bench expects at the head, in order.
module tb_fifo_sync_param;
    localparam int DEPTH = 16;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       err_clr;
    logic [4:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic [4:0] hwm;

    fifo_sync_param_if #(.DATA_W(32)) bus ();

    fifo_sync_param #(
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .AFULL_TH (12),
        .AEMPTY_TH(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .err_clr     (err_clr),
        .bus         (bus),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .hwm         (hwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    int          mdl_cnt = 0;
    int          mdl_hwm = 0;
    bit          mdl_ovf = 0;

    // Drive one cycle of stimulus, advance past the edge and update the model.
    task automatic clk_cycle(input logic iv, input logic [31:0] d, input logic ordy,
                             input logic fl, input logic ec);
        bit full_m, do_push, do_pop;
        full_m  = (mdl_cnt == DEPTH);
        do_push = iv && !full_m && !fl;
        do_pop  = ordy && (mdl_cnt > 0) && !fl;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        err_clr       = ec;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        err_clr       = 1'b0;
        if (iv && full_m) mdl_ovf = 1'b1;
        else if (ec)      mdl_ovf = 1'b0;
        if (fl) begin
            sb.delete();
            mdl_cnt = 0;
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(d);
            mdl_cnt = mdl_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        end
        if (ec || mdl_cnt > mdl_hwm) mdl_hwm = mdl_cnt;
    endtask

    task automatic test_reset();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull: got %b want 0", almost_full); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rst_aempty: got %b want 1", almost_empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        checks++; if (hwm !== 5'd0) begin errors++; $display("FAIL rst_hwm: got %0d want 0", hwm); end
    endtask

    task automatic test_single();
        clk_cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== sb[0]) begin errors++; $display("FAIL single_data: got %h want %h", bus.out_data, sb[0]); end
        checks++; if (count !== 5'(mdl_cnt)) begin errors++; $display("FAIL single_count: got %0d want %0d", count, mdl_cnt); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL single_aempty: got %b want 1", almost_empty); end
        clk_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", count); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL single_data0: got %h want 0", bus.out_data); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            clk_cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            checks++; if (count !== 5'(mdl_cnt)) begin errors++; $display("FAIL fill_count: got %0d want %0d", count, mdl_cnt); end
            checks++; if (almost_full !== (mdl_cnt >= 12)) begin errors++; $display("FAIL fill_afull: got %b at count %0d", almost_full, mdl_cnt); end
        end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count16: got %0d want 16", count); end
        checks++; if (hwm !== 5'd16) begin errors++; $display("FAIL fill_hwm: got %0d want 16", hwm); end
    endtask

    task automatic test_overflow();
        clk_cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d want 16", count); end
        clk_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", overflow); end
        checks++; if (hwm !== 5'(mdl_hwm)) begin errors++; $display("FAIL ovf_hwm: got %0d want %0d", hwm, mdl_hwm); end
    endtask

    task automatic test_drain();
        while (mdl_cnt > 0) begin
            checks++; if (bus.out_data !== sb[0]) begin errors++; $display("FAIL drain_data: got %h want %h", bus.out_data, sb[0]); end
            checks++; if (almost_empty !== (mdl_cnt <= 2)) begin errors++; $display("FAIL drain_aempty: got %b at count %0d", almost_empty, mdl_cnt); end
            clk_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", bus.out_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) clk_cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            checks++; if (bus.out_data !== sb[0]) begin errors++; $display("FAIL b2b_data: got %h want %h", bus.out_data, sb[0]); end
            clk_cycle(1'b1, 32'h300 + 32'(i), 1'b1, 1'b0, 1'b0);
            checks++; if (count !== 5'd5) begin errors++; $display("FAIL b2b_count: got %0d want 5", count); end
        end
        while (mdl_cnt > 0) begin
            checks++; if (bus.out_data !== sb[0]) begin errors++; $display("FAIL b2b_tail: got %h want %h", bus.out_data, sb[0]); end
            clk_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 9; i++) clk_cycle(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
        clk_cycle(1'b1, 32'h4FF, 1'b1, 1'b1, 1'b0);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", bus.in_ready); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL flush_aempty: got %b want 1", almost_empty); end
        checks++; if (hwm !== 5'(mdl_hwm)) begin errors++; $display("FAIL flush_hwm: got %0d want %0d", hwm, mdl_hwm); end
        checks++; if (overflow !== mdl_ovf) begin errors++; $display("FAIL flush_ovf: got %b want %b", overflow, mdl_ovf); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) clk_cycle(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        mdl_cnt = 0;
        mdl_hwm = 0;
        mdl_ovf = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL arst_data: got %h want 0", bus.out_data); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", bus.in_ready); end
        checks++; if (hwm !== 5'd0) begin errors++; $display("FAIL arst_hwm: got %0d want 0", hwm); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL arst_aempty: got %b want 1", almost_empty); end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        clk_cycle(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL arst_push_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== sb[0]) begin errors++; $display("FAIL arst_push_data: got %h want %h", bus.out_data, sb[0]); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL arst_push_count: got %0d want 1", count); end
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        err_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_single();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO for the AES verify-platform controller. It is the generalised successor of the fixed 32-bit FIFO.
- Buffers words between the host/stimulus interface and the AES core: 32-bit words for key/plaintext, or DATA_W=128 for whole blocks.
- Valid/ready handshakes on both sides, first-word-fall-through (FWFT) read, occupancy count, programmable almost-full/almost-empty flags.
- Debug aids: synchronous flush, sticky overflow flag, high-water-mark register.

Parameters:
- DATA_W, 32, word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AFULL_TH, DEPTH-4, almost_full asserts when count >= AFULL_TH (1..DEPTH).
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1).
- Derived localparam AW = log2(DEPTH); counts are AW+1 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of contents, count and pointers.
- in_valid  in  1  write request.
- in_data  in  DATA_W  write data.
- in_ready  out  1  FIFO can accept a word (= !full).
- out_valid  out  1  head word available (= !empty).
- out_data  out  DATA_W  head word (FWFT); 0 when out_valid=0.
- out_ready  in  1  consumer accepts head word.
- count  out  AW+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- overflow  out  1  sticky: write attempted while full.
- err_clr  in  1  clears overflow and hwm.
- hwm  out  AW+1  maximum count reached since reset/err_clr.

Behaviour:
- Reset is asynchronous, active-low, on clk domain. Reset values:
  - wr_ptr=rd_ptr=0, count=0, in_ready=1, out_valid=0, out_data=0
  - almost_full=0 (AFULL_TH>=1), almost_empty=1, overflow=0, hwm=0
  - Storage array is not reset.
- Pointers: wr_ptr and rd_ptr are AW+1 bits and wrap modulo 2*DEPTH.
  - Index = low AW bits.
  - full = (ptr MSBs differ && low bits equal); empty = (ptrs equal).
- Push: in_valid && in_ready at the clock edge.
  - Writes mem[wr_ptr] and increments wr_ptr.
- Pop: out_valid && out_ready at the clock edge.
  - Increments rd_ptr.
- FWFT read: out_data = mem[rd_ptr] combinationally whenever out_valid=1, and is forced to 0 otherwise.
- Latency: a word pushed into an empty FIFO at edge N gives out_valid=1 and out_data=word in the cycle after edge N.
- Count update (registered): count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged and moves both pointers.
  - When full: in_ready=0, so no push is possible. A pop in the same cycle is taken, and in_ready rises the next cycle. There is no same-cycle pass-through.
  - When empty: out_valid=0, so no pop is possible. A push is taken.
- Flags are combinational from registered count and pointers: full, empty, almost_full, almost_empty.
- Overflow: set when in_valid=1 && full at an edge. The word is dropped and the pointers are unchanged.
  - overflow holds until err_clr or reset.
  - err_clr and a new overflow event in the same cycle: the set wins.
- hwm: on each edge, if count_next > hwm then hwm <= count_next.
  - err_clr loads hwm <= count_next (not 0), so the current level is retained.
- Flush (priority over push/pop in the same cycle):
  - Pointers and count go to 0 at the edge; any push or pop in that cycle is ignored.
  - overflow and hwm are unaffected.
  - Next cycle: out_valid=0, in_ready=1, almost_empty=1.
- Handshake rules:
  - in_ready and out_valid do not depend combinationally on in_valid or out_ready.
  - No combinational path from input handshake to output handshake.
- Reset mid-operation: all state returns to the reset values immediately (asynchronously). Data in flight is lost.
- No behaviour is defined for DEPTH that is not a power of two; an elaboration-time check is required.

Test Plan (DATA_W=32, DEPTH=16, AFULL_TH=12, AEMPTY_TH=2):
1. Reset, then push 0x11111111.
   -> Next cycle out_valid=1, out_data=0x11111111, count=1, almost_empty=1.
   -> Pop it: count=0, out_data=0.
2. Push 16 words 0x00000000..0x0000000F with out_ready=0.
   -> almost_full rises when count reaches 12; after 16, in_ready=0, count=16, hwm=16.
   -> Pop all: data order 0x0..0xF, almost_empty at count<=2, empty at the end.
3. Full FIFO, in_valid=1 with 0xDEADBEEF.
   -> overflow=1, count stays 16, 0xDEADBEEF never appears at the output.
   -> Pulse err_clr: overflow=0, hwm=16.
4. Count=5; push and pop in the same cycle for 40 cycles with an incrementing pattern.
   -> count stays 5, output order is preserved across pointer wrap (>2*DEPTH writes).
5. Count=9; assert flush with in_valid=1 and out_ready=1 in the same cycle.
   -> Next cycle count=0, out_valid=0, in_ready=1; hwm and overflow unchanged.
6. Count=7; drop rst_n asynchronously mid-cycle.
   -> All outputs go to their reset values immediately; after release, push 0xA5A5A5A5, which is the next head word.
